masked_subbytes_sequencer: RTL and testbench
============================================

// Module: masked_subbytes_sequencer
// PURPOSE
//  Byte-serial SubBytes engine for a masked AES-128 datapath. Accepts one full masked 128-bit
//  state, streams its 16 bytes through a single external masked S-box instance, and writes the
//  pipelined S-box results back into an output state register. Sits between the round
//  controller (upstream, valid/ready) and the masked S-box, which is instantiated by the parent.
// PARAMETERS
//  NUM_SHARES    2  number of Boolean shares per byte (>=2)
//  SBOX_LATENCY  3  clock cycles from S-box input to S-box output (must match the S-box stage type)
// PORTS
//  in_clock      in   1                  clock; all state updates on rising edge
//  in_reset      in   1                  synchronous, active-high reset
//  in_state      in   bv8_t[16][SH]      masked input state, byte i = row + 4*col
//  in_enc        in   1                  1 = encryption (S-box), 0 = decryption (inverse S-box)
//  in_valid      in   1                  in_state/in_enc valid
//  out_ready     out  1                  sequencer can accept a state (IDLE only)
//  out_sbox_a    out  bv8_t[SH]          masked byte to S-box
//  out_sbox_enc  out  1                  direction to S-box, latched copy of in_enc
//  in_sbox_b     in   bv8_t[SH]          masked byte from S-box, SBOX_LATENCY cycles after out_sbox_a
//  out_state     out  bv8_t[16][SH]      masked SubBytes result
//  out_valid     out  1                  out_state valid
//  in_ready      in   1                  downstream accepts out_state
// BEHAVIOUR
//  - FSM: IDLE -> FEED -> DRAIN -> DONE -> IDLE.
//  - IDLE: out_ready=1. in_valid&out_ready -> latch in_state into input regs, latch in_enc,
//    feed counter k=0, go FEED. in_valid in any other state is ignored (no latch).
//  - FEED: 16 cycles; cycle k drives out_sbox_a = input byte k, k = 0..15; k wraps to 15 -> DRAIN.
//  - out_sbox_a = all-zero shares outside FEED (never a stale share); out_sbox_enc held constant
//    from accept until return to IDLE.
//  - Tag pipe: {valid,index[3:0]} delayed SBOX_LATENCY cycles; when tag valid, in_sbox_b written
//    to out_state[dest(index)]. Byte k written at cycle k+SBOX_LATENCY after entering FEED.
//  - DRAIN: wait until tag pipe empty (last write done) -> DONE. Total accept-to-out_valid
//    latency = 16 + SBOX_LATENCY + 1 cycles.
//  - DONE: out_valid=1, out_state stable; out_valid&in_ready -> IDLE (out_valid falls next cycle).
//    No new state accepted in the handshake cycle.
//  - Shares are never combined; each share processed independently, no share-wise XOR of registers.
//  - Reset (any state, incl. mid-FEED/DRAIN): state IDLE, tag pipe cleared, out_valid=0,
//    out_ready=1 next cycle, out_sbox_enc=0, out_sbox_a=0, input and output regs cleared to 0.
// CONFIGURATION
//  MASKED_SUBBYTES_SHIFTROWS_EN defined: write-back fuses (Inv)ShiftRows. For source byte
//    j = r+4c: enc dest = r + 4*((c - r) mod 4); dec dest = r + 4*((c + r) mod 4).
//  Not defined: dest(j) = j (plain SubBytes); ShiftRows done elsewhere.
// STRUCTURE
//  aes128_package: masked state typedef (bv8_t[15:0][NUM_SHARES-1:0]), FSM state enum,
//    function shiftrows_dest(index, enc), sbox latency function per stage type.
//  Sub-module masked_tag_delay: SBOX_LATENCY-deep register line for {valid,index}, sync reset.
// TESTING
//  1 enc, share0=byte i value, other shares 0, state 00..0F -> recombined out 63 7C 77 7B F2 6B 6F C5
//    30 01 67 2B FE D7 AB 76; out_valid exactly 16+SBOX_LATENCY+1 cycles after accept.
//  2 dec, random masks per byte, recombined input 63 repeated -> recombined out all 00;
//    53 -> ED in enc confirms per-share independence.
//  3 Hold in_ready=0 for 5 cycles in DONE -> out_state/out_valid stable; in_valid pulses ignored.
//  4 in_reset at FEED k=7 -> next cycle out_ready=1, out_valid=0, out_sbox_a=0; following state
//    processed correctly with no writes from flushed tags.
//  5 SHIFTROWS_EN, enc, share0 bytes 00..0F -> out byte 1 = S(05), byte 5 = S(09), byte 2 = S(0A);
//    dec -> out byte 1 = S^-1(0D). Without macro -> out byte j = S(j).
//  6 Back-to-back: in_valid held high -> second accept exactly one cycle after first DONE handshake.

Source files
------------

// File: rtl/masked_subbytes_sequencer_pkg.sv
// Shared types and helpers for the masked byte-serial SubBytes sequencer:
// masked state typedef, sequencer FSM states, S-box latency per stage type
// and the fused (Inv)ShiftRows destination index.
package masked_subbytes_sequencer_pkg;

    localparam int NUM_BYTES          = 16;
    localparam int NUM_SHARES_DEFAULT = 2;

    typedef logic [7:0] bv8_t;
    typedef bv8_t [NUM_BYTES-1:0][NUM_SHARES_DEFAULT-1:0] masked_state_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FEED  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_e;

    // Known masked S-box micro-architectures and their input-to-output latency.
    typedef enum logic [1:0] {
        SBOX_STAGE_REG      = 2'd0,
        SBOX_STAGE_DOM      = 2'd1,
        SBOX_STAGE_DOM_FULL = 2'd2
    } sbox_stage_e;

    function automatic int sbox_latency(input sbox_stage_e stage);
        case (stage)
            SBOX_STAGE_REG:      return 1;
            SBOX_STAGE_DOM:      return 3;
            SBOX_STAGE_DOM_FULL: return 5;
            default:             return 3;
        endcase
    endfunction

    // Byte j = row + 4*col. Encryption moves it to column (col - row) mod 4,
    // decryption to column (col + row) mod 4; the row never changes.
    function automatic logic [3:0] shiftrows_dest(input logic [3:0] index, input logic enc);
        logic [1:0] row;
        logic [1:0] col;
        logic [1:0] col_dst;
        row     = index[1:0];
        col     = index[3:2];
        col_dst = enc ? (col - row) : (col + row);
        return {col_dst, row};
    endfunction

endpackage

// File: rtl/masked_subbytes_sequencer_tag_delay.sv
// masked_tag_delay: DEPTH-stage register line carrying {valid, index} tags
// alongside the external S-box pipeline. busy_o flags any valid tag in flight.
module masked_tag_delay #(
    parameter int DEPTH = 3,
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             srst,
    input  logic [WIDTH-1:0] tag_i,
    output logic [WIDTH-1:0] tag_o,
    output logic             busy_o
);

    logic [WIDTH-1:0] stage_q [DEPTH];

    // Shift tags one stage per cycle; reset flushes every stage.
    always_ff @(posedge clk) begin
        if (srst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= tag_i;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    // Any valid bit (MSB) anywhere in the line means a write is still pending.
    always_comb begin
        busy_o = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            busy_o = busy_o | stage_q[i][WIDTH-1];
        end
    end

    assign tag_o = stage_q[DEPTH-1];

endmodule

// File: rtl/masked_subbytes_sequencer.sv
// Byte-serial masked SubBytes sequencer. Streams the 16 bytes of a latched
// masked state through one external masked S-box and collects the results.
// Shares are moved around untouched; they are never combined here.
// Optional macro MASKED_SUBBYTES_SHIFTROWS_EN fuses (Inv)ShiftRows into the
// write-back address; otherwise byte j is written back to position j.
module masked_subbytes_sequencer
    import masked_subbytes_sequencer_pkg::*;
#(
    parameter int NUM_SHARES   = 2,
    parameter int SBOX_LATENCY = sbox_latency(SBOX_STAGE_DOM)
) (
    input  logic                                  in_clock,
    input  logic                                  in_reset,
    input  logic [NUM_BYTES-1:0][NUM_SHARES-1:0][7:0] in_state,
    input  logic                                  in_enc,
    input  logic                                  in_valid,
    output logic                                  out_ready,
    output logic [NUM_SHARES-1:0][7:0]            out_sbox_a,
    output logic                                  out_sbox_enc,
    input  logic [NUM_SHARES-1:0][7:0]            in_sbox_b,
    output logic [NUM_BYTES-1:0][NUM_SHARES-1:0][7:0] out_state,
    output logic                                  out_valid,
    input  logic                                  in_ready
);

    seq_state_e state_q, state_d;
    logic [3:0] k_q, k_d;
    logic       accept;
    logic       enc_q;
    logic [NUM_BYTES-1:0][NUM_SHARES-1:0][7:0] in_regs_q;

    logic [4:0] tag_in;
    logic [4:0] tag_out;
    logic       tag_busy;
    logic [3:0] wr_dest;

    // Next-state, feed counter and handshake outputs.
    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        accept    = 1'b0;
        out_ready = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            ST_IDLE: begin
                out_ready = 1'b1;
                if (in_valid) begin
                    accept  = 1'b1;
                    k_d     = 4'd0;
                    state_d = ST_FEED;
                end
            end
            ST_FEED: begin
                k_d = k_q + 4'd1;
                if (k_q == 4'd15) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!tag_busy) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (in_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register, feed counter, and input/direction latches taken on accept.
    always_ff @(posedge in_clock) begin
        if (in_reset) begin
            state_q   <= ST_IDLE;
            k_q       <= 4'd0;
            enc_q     <= 1'b0;
            in_regs_q <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            if (accept) begin
                in_regs_q <= in_state;
                enc_q     <= in_enc;
            end
        end
    end

    // S-box feed: current byte during FEED only, all-zero shares otherwise.
    always_comb begin
        out_sbox_a = '0;
        if (state_q == ST_FEED) begin
            out_sbox_a = in_regs_q[k_q];
        end
    end

    assign out_sbox_enc = enc_q;
    assign tag_in       = {state_q == ST_FEED, k_q};

    masked_tag_delay #(
        .DEPTH (SBOX_LATENCY),
        .WIDTH (5)
    ) u_tag_delay (
        .clk    (in_clock),
        .srst   (in_reset),
        .tag_i  (tag_in),
        .tag_o  (tag_out),
        .busy_o (tag_busy)
    );

`ifdef MASKED_SUBBYTES_SHIFTROWS_EN
    assign wr_dest = shiftrows_dest(tag_out[3:0], enc_q);
`else
    assign wr_dest = tag_out[3:0];
`endif

    generate
        for (genvar gi = 0; gi < NUM_BYTES; gi++) begin : g_out_byte
            logic [NUM_SHARES-1:0][7:0] byte_q;

            // Capture the returning S-box shares when the tag addresses this byte.
            always_ff @(posedge in_clock) begin
                if (in_reset) begin
                    byte_q <= '0;
                end else if (tag_out[4] && (wr_dest == 4'(gi))) begin
                    byte_q <= in_sbox_b;
                end
            end

            assign out_state[gi] = byte_q;
        end
    endgenerate

endmodule

// File: tb/tb_masked_subbytes_sequencer.sv
// Directed bench for masked_subbytes_sequencer with a behavioural masked
// S-box (recombine, look up, re-split with fresh masks, SBOX_LAT cycles).
// Honours MASKED_SUBBYTES_SHIFTROWS_EN when computing expected placement.
module tb_masked_subbytes_sequencer;

    localparam int SH       = 2;
    localparam int SBOX_LAT = 3;
    localparam int EXP_LAT  = 16 + SBOX_LAT + 1;

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    logic                          in_clock;
    logic                          in_reset;
    logic [15:0][SH-1:0][7:0]      in_state;
    logic                          in_enc;
    logic                          in_valid;
    logic                          out_ready;
    logic [SH-1:0][7:0]            out_sbox_a;
    logic                          out_sbox_enc;
    logic [SH-1:0][7:0]            in_sbox_b;
    logic [15:0][SH-1:0][7:0]      out_state;
    logic                          out_valid;
    logic                          in_ready;

    int checks = 0;
    int errors = 0;

    logic [7:0]         inv_tab [256];
    logic [SH-1:0][7:0] sb_pipe [SBOX_LAT];

    masked_subbytes_sequencer #(
        .NUM_SHARES   (SH),
        .SBOX_LATENCY (SBOX_LAT)
    ) dut (
        .in_clock     (in_clock),
        .in_reset     (in_reset),
        .in_state     (in_state),
        .in_enc       (in_enc),
        .in_valid     (in_valid),
        .out_ready    (out_ready),
        .out_sbox_a   (out_sbox_a),
        .out_sbox_enc (out_sbox_enc),
        .in_sbox_b    (in_sbox_b),
        .out_state    (out_state),
        .out_valid    (out_valid),
        .in_ready     (in_ready)
    );

    initial in_clock = 1'b0;
    always #5 in_clock = ~in_clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] recomb(input logic [SH-1:0][7:0] s);
        logic [7:0] x;
        x = 8'h00;
        for (int i = 0; i < SH; i++) x = x ^ s[i];
        return x;
    endfunction

    function automatic logic [SH-1:0][7:0] split(input logic [7:0] v, input logic masked);
        logic [SH-1:0][7:0] s;
        logic [7:0] acc;
        acc = 8'h00;
        for (int i = 1; i < SH; i++) begin
            s[i] = masked ? 8'($urandom_range(0, 255)) : 8'h00;
            acc  = acc ^ s[i];
        end
        s[0] = v ^ acc;
        return s;
    endfunction

    function automatic logic [SH-1:0][7:0] sbox_model(input logic [SH-1:0][7:0] a, input logic enc);
        logic [7:0] x;
        x = recomb(a);
        return split(enc ? SBOX[x] : inv_tab[x], 1'b1);
    endfunction

    // Behavioural masked S-box: fresh output masks, fixed latency.
    always @(posedge in_clock) begin
        sb_pipe[0] <= sbox_model(out_sbox_a, out_sbox_enc);
        for (int i = 1; i < SBOX_LAT; i++) sb_pipe[i] <= sb_pipe[i-1];
    end
    assign in_sbox_b = sb_pipe[SBOX_LAT-1];

    function automatic int dest_of(input int j, input logic enc);
`ifdef MASKED_SUBBYTES_SHIFTROWS_EN
        int r;
        int c;
        r = j % 4;
        c = j / 4;
        return enc ? (r + 4 * ((c - r + 4) % 4)) : (r + 4 * ((c + r) % 4));
`else
        if (enc) return j;
        return j;
`endif
    endfunction

    task automatic chk(input string nm, input logic [1023:0] act, input logic [1023:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    typedef struct {
        string          name;
        logic           enc;
        logic           masked;
        logic [15:0][7:0] din;
        logic [15:0][7:0] sub;
    } vec_t;

    vec_t vecs [5];

    task automatic tick;
        @(posedge in_clock);
        #1;
    endtask

    task automatic accept_state(input logic [15:0][7:0] din, input logic enc, input logic masked,
                                input string nm);
        for (int j = 0; j < 16; j++) in_state[j] = split(din[j], masked);
        in_enc   = enc;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk({nm, "_accepted"}, 1024'(out_ready), 1024'(1'b0));
        chk({nm, "_feed_byte0"}, 1024'(recomb(out_sbox_a)), 1024'(din[0]));
        chk({nm, "_sbox_enc"}, 1024'(out_sbox_enc), 1024'(enc));
    endtask

    task automatic wait_valid(input string nm);
        int cyc;
        cyc = 0;
        while (!out_valid && cyc < 200) begin
            tick();
            cyc++;
        end
        chk({nm, "_latency"}, 1024'(cyc), 1024'(EXP_LAT));
    endtask

    task automatic check_result(input logic [15:0][7:0] sub, input logic enc, input string nm,
                                output logic [15:0][7:0] got);
        logic [15:0][7:0] exp;
        for (int j = 0; j < 16; j++) begin
            got[j] = recomb(out_state[j]);
            exp[dest_of(j, enc)] = sub[j];
        end
        chk({nm, "_data"}, 1024'(got), 1024'(exp));
        $display("txn %s enc=%0d out=%h", nm, enc, got);
    endtask

    task automatic handshake(input string nm);
        in_ready = 1'b1;
        tick();
        in_ready = 1'b0;
        chk({nm, "_valid_drop"}, 1024'(out_valid), 1024'(1'b0));
        chk({nm, "_ready_back"}, 1024'(out_ready), 1024'(1'b1));
    endtask

    task automatic run_vec(input vec_t v, output logic [15:0][7:0] got);
        accept_state(v.din, v.enc, v.masked, v.name);
        wait_valid(v.name);
        check_result(v.sub, v.enc, v.name, got);
        handshake(v.name);
    endtask

    initial begin
        logic [15:0][7:0] got;
        logic [15:0][SH-1:0][7:0] snap;

        for (int i = 0; i < 256; i++) inv_tab[SBOX[i]] = 8'(i);

        vecs[0] = '{"enc_seq",      1'b1, 1'b0, 128'h0f0e0d0c0b0a09080706050403020100,
                                                128'h76abd7fe2b670130c56f6bf27b777c63};
        vecs[1] = '{"dec_63",       1'b0, 1'b1, {16{8'h63}}, {16{8'h00}}};
        vecs[2] = '{"enc_53",       1'b1, 1'b1, {16{8'h53}}, {16{8'hed}}};
        vecs[3] = '{"dec_seq",      1'b0, 1'b1, 128'h0f0e0d0c0b0a09080706050403020100,
                                                128'hfbd7f3819ea340bf38a53630d56a0952};
        vecs[4] = '{"enc_seq_mask", 1'b1, 1'b1, 128'h0f0e0d0c0b0a09080706050403020100,
                                                128'h76abd7fe2b670130c56f6bf27b777c63};

        in_reset = 1'b1;
        in_state = '0;
        in_enc   = 1'b0;
        in_valid = 1'b0;
        in_ready = 1'b0;
        repeat (4) tick();
        in_reset = 1'b0;
        tick();

        chk("rst_ready", 1024'(out_ready), 1024'(1'b1));
        chk("rst_valid", 1024'(out_valid), 1024'(1'b0));
        chk("rst_sbox_a", 1024'(out_sbox_a), 1024'(0));
        chk("rst_sbox_enc", 1024'(out_sbox_enc), 1024'(1'b0));
        chk("rst_out_state", 1024'(out_state), 1024'(0));

        for (int i = 0; i < 5; i++) begin
            run_vec(vecs[i], got);
`ifdef MASKED_SUBBYTES_SHIFTROWS_EN
            if (i == 0) begin
                chk("sr_enc_byte1", 1024'(got[1]), 1024'(8'h6b));
                chk("sr_enc_byte5", 1024'(got[5]), 1024'(8'h01));
                chk("sr_enc_byte2", 1024'(got[2]), 1024'(8'h67));
            end
            if (i == 3) chk("sr_dec_byte1", 1024'(got[1]), 1024'(8'hf3));
`else
            if (i == 0) chk("plain_byte5", 1024'(got[5]), 1024'(8'h6b));
`endif
        end

        // Stall in DONE with in_ready low; in_valid pulses must be ignored.
        accept_state(vecs[2].din, 1'b1, 1'b1, "hold");
        wait_valid("hold");
        snap = out_state;
        for (int c = 0; c < 5; c++) begin
            in_valid = c[0];
            for (int j = 0; j < 16; j++) in_state[j] = split(8'(c + 8'h20), 1'b1);
            in_enc = 1'b0;
            tick();
            chk("hold_valid", 1024'(out_valid), 1024'(1'b1));
            chk("hold_ready", 1024'(out_ready), 1024'(1'b0));
            chk("hold_state", 1024'(out_state), 1024'(snap));
        end
        in_valid = 1'b0;
        check_result(vecs[2].sub, 1'b1, "hold", got);
        handshake("hold");

        // Reset in the middle of FEED (k = 7).
        accept_state(vecs[3].din, 1'b0, 1'b1, "midrst");
        repeat (7) tick();
        in_reset = 1'b1;
        tick();
        in_reset = 1'b0;
        chk("midrst_ready", 1024'(out_ready), 1024'(1'b1));
        chk("midrst_valid", 1024'(out_valid), 1024'(1'b0));
        chk("midrst_sbox_a", 1024'(out_sbox_a), 1024'(0));
        chk("midrst_sbox_enc", 1024'(out_sbox_enc), 1024'(1'b0));
        tick();
        chk("midrst_out_state", 1024'(out_state), 1024'(0));
        run_vec(vecs[0], got);

        // Back-to-back: in_valid held through the DONE handshake.
        accept_state(vecs[2].din, 1'b1, 1'b1, "b2b_a");
        wait_valid("b2b_a");
        check_result(vecs[2].sub, 1'b1, "b2b_a", got);
        for (int j = 0; j < 16; j++) in_state[j] = split(vecs[1].din[j], 1'b1);
        in_enc   = 1'b0;
        in_valid = 1'b1;
        in_ready = 1'b1;
        tick();
        in_ready = 1'b0;
        chk("b2b_hs_idle", 1024'(out_ready), 1024'(1'b1));
        chk("b2b_hs_valid", 1024'(out_valid), 1024'(1'b0));
        tick();
        in_valid = 1'b0;
        chk("b2b_second_accept", 1024'(out_ready), 1024'(1'b0));
        chk("b2b_feed_byte0", 1024'(recomb(out_sbox_a)), 1024'(8'h63));
        wait_valid("b2b_b");
        check_result(vecs[1].sub, 1'b0, "b2b_b", got);
        handshake("b2b_b");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
